// File: rtl/maze_collision_lives.sv
// Collision and game-state unit for the maze runner.
// Player contacts are accumulated across a video frame and resolved once on the
// frame_end pulse. A lives counter with post-hit invulnerability drives the
// ALIVE/HIT/WIN/LOSE state machine. The current state is exposed on state_dbg
// so that checkers can be bound to it.
module maze_collision_lives #(
    parameter int NUM_WALLS     = 115,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int LW            = $clog2(LIVES + 1),
    parameter int WW            = $clog2(NUM_WALLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_end,
    input  logic                 player,
    input  logic                 border,
    input  logic                 end_zone,
    input  logic [NUM_WALLS-1:0] walls,
    input  logic [NUM_WALLS-1:0] wall_en,
    output logic                 win,
    output logic                 game_over,
    output logic [LW-1:0]        lives,
    output logic                 hit,
    output logic                 invuln,
    output logic [WW-1:0]        hit_wall,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_HIT   = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_t;

    // The invulnerability counter keeps at least one bit even when INVULN_FRAMES is 0.
    localparam int IW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    state_t               state_q, state_d;
    logic [LW-1:0]        lives_q, lives_d;
    logic [IW-1:0]        inv_cnt_q, inv_cnt_d;
    logic                 hit_d;
    logic [WW-1:0]        hit_wall_q, hit_wall_d;

    logic                 thump_seen, solved_seen, src_valid;
    logic [WW-1:0]        src_cap;

    logic [NUM_WALLS-1:0] wall_contact;
    logic                 wall_hit, thump, solved;
    logic [WW-1:0]        cur_src;
    logic                 thump_f, solved_f;
    logic [WW-1:0]        src_f;

    assign wall_contact = walls & wall_en & {NUM_WALLS{player}};
    assign wall_hit     = |wall_contact;
    assign thump        = wall_hit | (player & border);
    assign solved       = player & end_zone;

    // The lowest contacted enabled wall wins; the border code is used only when no wall is touched.
    always_comb begin
        cur_src = WW'(NUM_WALLS);
        for (int i = NUM_WALLS - 1; i >= 0; i--) begin
            if (wall_contact[i]) begin
                cur_src = WW'(i);
            end
        end
    end

    // The frame_end cycle's own contact belongs to the frame that is ending.
    assign thump_f  = thump_seen | thump;
    assign solved_f = solved_seen | solved;
    assign src_f    = src_valid ? src_cap : cur_src;

    // Per-frame sticky contact flags, cleared on every frame boundary.
    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            thump_seen  <= 1'b0;
            solved_seen <= 1'b0;
            src_valid   <= 1'b0;
            src_cap     <= '0;
        end else begin
            if (thump) begin
                thump_seen <= 1'b1;
                if (!src_valid) begin
                    src_cap   <= cur_src;
                    src_valid <= 1'b1;
                end
            end
            if (solved) begin
                solved_seen <= 1'b1;
            end
        end
    end

    // Next-state logic: everything is resolved only on frame_end; otherwise hold.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        inv_cnt_d  = inv_cnt_q;
        hit_d      = 1'b0;
        hit_wall_d = hit_wall_q;
        if (frame_end) begin
            case (state_q)
                ST_ALIVE: begin
                    if (solved_f) begin
                        state_d = ST_WIN;
                    end else if (thump_f) begin
                        hit_d      = 1'b1;
                        hit_wall_d = src_f;
                        if (lives_q <= LW'(1)) begin
                            lives_d = '0;
                            state_d = ST_LOSE;
                        end else begin
                            lives_d = lives_q - LW'(1);
                            if (INVULN_FRAMES > 0) begin
                                inv_cnt_d = IW'(INVULN_FRAMES);
                                state_d   = ST_HIT;
                            end
                        end
                    end
                end
                ST_HIT: begin
                    if (solved_f) begin
                        state_d = ST_WIN;
                    end else if (inv_cnt_q <= IW'(1)) begin
                        inv_cnt_d = '0;
                        state_d   = ST_ALIVE;
                    end else begin
                        inv_cnt_d = inv_cnt_q - IW'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and output registers; the flag outputs are decoded from the next state so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ALIVE;
            lives_q    <= LW'(LIVES);
            inv_cnt_q  <= '0;
            hit_wall_q <= '0;
            hit        <= 1'b0;
            win        <= 1'b0;
            game_over  <= 1'b0;
            invuln     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            inv_cnt_q  <= inv_cnt_d;
            hit_wall_q <= hit_wall_d;
            hit        <= hit_d;
            win        <= (state_d == ST_WIN);
            game_over  <= (state_d == ST_LOSE);
            invuln     <= (state_d == ST_HIT);
        end
    end

    assign lives     = lives_q;
    assign hit_wall  = hit_wall_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_maze_collision_lives.sv
// Directed bench for maze_collision_lives with a frame-level reference model
// and an expected-output queue compared every cycle.
module tb_maze_collision_lives;

    localparam int NW = 115;
    localparam int NI = 60;
    localparam int LW = 2;
    localparam int WW = 7;
    localparam int OW = 1 + 1 + LW + 1 + 1 + WW + 2;

    logic          clk = 1'b0;
    logic          rst, frame_end, player, border, end_zone;
    logic [NW-1:0] walls, wall_en;
    logic          win, game_over, hit, invuln;
    logic [LW-1:0] lives;
    logic [WW-1:0] hit_wall;
    logic [1:0]    state_dbg;

    maze_collision_lives dut (
        .clk(clk), .rst(rst), .frame_end(frame_end), .player(player),
        .border(border), .end_zone(end_zone), .walls(walls), .wall_en(wall_en),
        .win(win), .game_over(game_over), .lives(lives), .hit(hit),
        .invuln(invuln), .hit_wall(hit_wall), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    logic [OW-1:0] exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    string         tag      = "init";

    // frame-level reference model: 0=ALIVE 1=HIT 2=WIN 3=LOSE
    int   m_state, m_lives, m_cnt, m_hw, f_src;
    logic m_hit, f_thump, f_solved, f_valid;

    // stimulus globals used by the frame() driver
    logic          c_b, c_ez;
    logic [NW-1:0] c_w, c_en, vw;

    function automatic int lowest_src(input logic p, input logic b,
                                      input logic [NW-1:0] w, input logic [NW-1:0] en);
        for (int i = 0; i < NW; i++) begin
            if (p && w[i] && en[i]) return i;
        end
        if (p && b) return NW;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = 3; m_cnt = 0; m_hw = 0; m_hit = 1'b0;
        f_thump = 1'b0; f_solved = 1'b0; f_valid = 1'b0; f_src = 0;
    endtask

    // Drive one cycle, advance the model, queue the expectation, then compare at the next negedge.
    task automatic step(input logic r, input logic fe, input logic p, input logic b,
                        input logic ez, input logic [NW-1:0] w, input logic [NW-1:0] en);
        int            s_now;
        logic          t, s;
        int            src;
        logic [OW-1:0] got, exp;
        rst = r; frame_end = fe; player = p; border = b; end_zone = ez;
        walls = w; wall_en = en;
        s_now = lowest_src(p, b, w, en);
        m_hit = 1'b0;
        if (r) begin
            model_reset();
        end else if (fe) begin
            t   = f_thump | (s_now >= 0);
            s   = f_solved | (p & ez);
            src = f_valid ? f_src : s_now;
            if (m_state == 0) begin
                if (s) m_state = 2;
                else if (t) begin
                    m_hit = 1'b1;
                    m_hw  = src;
                    if (m_lives == 1) begin
                        m_lives = 0; m_state = 3;
                    end else begin
                        m_lives = m_lives - 1; m_cnt = NI; m_state = 1;
                    end
                end
            end else if (m_state == 1) begin
                if (s) m_state = 2;
                else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_state = 0;
                end
            end
            f_thump = 1'b0; f_solved = 1'b0; f_valid = 1'b0;
        end else begin
            if (s_now >= 0) begin
                f_thump = 1'b1;
                if (!f_valid) begin
                    f_valid = 1'b1; f_src = s_now;
                end
            end
            if (p && ez) f_solved = 1'b1;
        end
        exp_q.push_back({(m_state == 2), (m_state == 3), LW'(m_lives), m_hit,
                         (m_state == 1), WW'(m_hw), 2'(m_state)});
        @(negedge clk);
        got = {win, game_over, lives, hit, invuln, hit_wall, state_dbg};
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle_check=%0d got=%h expected=%h", tag, checks, got, exp);
        end
    endtask

    // Directed anchor check against a constant written from the game rules.
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // mode 0: no contact, 1: contact on one mid cycle, 2: contact every cycle, 3: contact on the frame_end cycle only
    task automatic frame(input int mode, input int len);
        logic fe, act;
        for (int i = 0; i < len; i++) begin
            fe  = (i == len - 1);
            act = (mode == 2) || (mode == 1 && i == (len - 1) / 2) || (mode == 3 && fe);
            step(1'b0, fe, act, c_b, c_ez, c_w, c_en);
        end
    endtask

    initial begin
        rst = 1'b1; frame_end = 1'b0; player = 1'b0; border = 1'b0; end_zone = 1'b0;
        walls = '0; wall_en = '1;
        c_b = 1'b0; c_ez = 1'b0; c_w = '0; c_en = '1; vw = '0;
        model_reset();
        @(negedge clk);

        tag = "reset";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '1);
        repeat (3) frame(0, 4);
        chk("reset_lives", 32'(lives), 3);
        chk("reset_flags", 32'({win, game_over, invuln, hit}), 0);

        tag = "wall7";
        c_w = '0; c_w[7] = 1'b1;
        frame(1, 4);
        chk("wall7_hit_pulse", 32'(hit), 1);
        chk("wall7_lives", 32'(lives), 2);
        chk("wall7_hit_wall", 32'(hit_wall), 7);
        chk("wall7_invuln", 32'(invuln), 1);

        tag = "invuln";
        repeat (59) frame(2, 4);
        chk("invuln_lives_held", 32'(lives), 2);
        chk("invuln_still_high", 32'(invuln), 1);
        c_w = '0;
        frame(0, 4);
        chk("invuln_dropped", 32'(invuln), 0);

        tag = "mask_lowest";
        c_w[3] = 1'b1; c_w[40] = 1'b1; c_en[3] = 1'b0;
        frame(1, 4);
        chk("mask_lives", 32'(lives), 1);
        chk("mask_hit_wall", 32'(hit_wall), 40);
        c_w = '0; c_en = '1;
        repeat (60) frame(0, 4);
        chk("mask_invuln_over", 32'(invuln), 0);

        tag = "masked_only";
        c_w[5] = 1'b1; c_en[5] = 1'b0;
        frame(2, 4);
        chk("masked_no_hit_lives", 32'(lives), 1);

        tag = "border_fatal";
        c_w = '0; c_en = '1; c_b = 1'b1;
        frame(1, 4);
        chk("fatal_lives", 32'(lives), 0);
        chk("fatal_game_over", 32'(game_over), 1);
        chk("fatal_hit_wall", 32'(hit_wall), NW);

        tag = "lose_hold";
        c_w[9] = 1'b1; c_ez = 1'b1;
        repeat (3) frame(2, 4);
        chk("lose_hold_flags", 32'({win, game_over, lives}), 32'({1'b0, 1'b1, 2'd0}));

        tag = "rst_override";
        vw = '0; vw[9] = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, vw, '1);
        chk("rst_override_lives", 32'(lives), 3);
        chk("rst_override_game_over", 32'(game_over), 0);

        tag = "priority";
        c_b = 1'b0; c_ez = 1'b0; c_w = '0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, vw, '1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, '0, '1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '1);
        chk("priority_win", 32'(win), 1);
        chk("priority_lives", 32'(lives), 3);
        c_w[7] = 1'b1;
        repeat (2) frame(2, 4);
        chk("win_hold", 32'({win, game_over, lives}), 32'({1'b1, 1'b0, 2'd3}));

        tag = "edge_cycle";
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '1);
        c_w = '0; c_w[20] = 1'b1;
        frame(3, 4);
        chk("edge_hit", 32'(hit), 1);
        chk("edge_lives", 32'(lives), 2);
        chk("edge_hit_wall", 32'(hit_wall), 20);

        tag = "back_to_back";
        repeat (5) frame(2, 1);
        chk("b2b_lives", 32'(lives), 2);
        chk("b2b_invuln", 32'(invuln), 1);

        tag = "hit_to_win";
        c_ez = 1'b1;
        frame(1, 1);
        chk("hit_to_win", 32'(win), 1);

        tag = "rst_mid_hit";
        c_ez = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '1);
        frame(1, 4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '1);
        chk("rst_mid_hit_lives", 32'(lives), 3);
        chk("rst_mid_hit_invuln", 32'(invuln), 0);

        tag = "first_capture";
        vw = '0; vw[50] = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, vw, '1);
        vw = '0; vw[10] = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, vw, '1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '1);
        chk("first_capture_hit_wall", 32'(hit_wall), 50);
        frame(0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
